// File: rtl/amp_pwm_dac.sv
// amp_pwm_dac: output stage of the DDS amplitude path.
// Takes the 2*M-bit product from the sequential amplitude multiplier,
// rounds it (round half up) to OUT_W bits with saturation, and plays it
// as a single-bit PWM stream with period 2^OUT_W clocks. A new duty is
// adopted only at a period boundary, so a period is never cut short or
// stretched by an update.
//
// Input handshake: prod_valid is a one-cycle strobe with no ready. The
// block always accepts the strobe. prod must be complete and stable in
// that cycle. A sample that is still pending is overwritten by a newer
// one, and the sticky overrun flag records that this happened.
module amp_pwm_dac #(
  parameter int M     = 12,
  parameter int OUT_W = 8   // must be smaller than 2*M
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*M-1:0]     prod,
  input  logic               prod_valid,
  input  logic               en,
  output logic               pwm_out,
  output logic [OUT_W-1:0]   duty_q,
  output logic               period_start,
  output logic               overrun
);

  // Rounding datapath
  logic [OUT_W-1:0] prod_top;
  logic             round_bit;
  logic [OUT_W:0]   round_sum;
  logic [OUT_W-1:0] rounded;

  // Pending sample buffer and PWM state
  logic [OUT_W-1:0] pending;
  logic             pending_valid;
  logic [OUT_W-1:0] cnt;

  // Boundary decode
  logic             boundary;
  logic             consume;
  logic [OUT_W-1:0] duty_next;

  // Round half up. The sum is one bit wider so that a carry out of the
  // top bits can be detected. A carry means the rounded value would not
  // fit in OUT_W bits, so the output clamps to full scale.
  always_comb begin
    prod_top  = prod[2*M-1 -: OUT_W];
    round_bit = prod[2*M-1-OUT_W];
    round_sum = {1'b0, prod_top} + {{OUT_W{1'b0}}, round_bit};
    rounded   = round_sum[OUT_W] ? {OUT_W{1'b1}} : round_sum[OUT_W-1:0];
  end

  // A boundary is the cnt=0 slot while running. At a boundary the sample
  // that was pending before this cycle is consumed. The duty used for
  // this cycle's compare already includes that update, so a new duty
  // applies from cnt=0.
  always_comb begin
    boundary  = en && (cnt == '0);
    consume   = boundary && pending_valid;
    duty_next = consume ? pending : duty_q;
  end

  // Period counter: free-runs while enabled and is held at 0 otherwise.
  // Because of the hold, the first cycle after en rises is a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Pending buffer. A capture in the same cycle as a consume is not an
  // overrun, because the older value has just gone to duty_q. The new
  // value waits for the next boundary. There is no bypass to duty_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (prod_valid) begin
        pending       <= rounded;
        pending_valid <= 1'b1;
        if (pending_valid && !consume) begin
          overrun <= 1'b1;
        end
      end else if (consume) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // Duty register: changes only when a boundary consumes a pending sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
    end else if (consume) begin
      duty_q <= duty_next;
    end
  end

  // Registered outputs. cnt runs over 0..2^OUT_W-1 and the output is
  // high while cnt < duty, so a duty of D gives exactly D high cycles per
  // period. period_start lines up with the pwm_out sample for cnt=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= en && (cnt < duty_next);
      period_start <= boundary;
    end
  end

endmodule
